// File: rtl/way_allocator_pkg.sv
// Shared cache-set definitions: allocator FSM encoding and the LRU matrix reset order.
package way_allocator_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EVICT = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;

    // The reset order is equivalent to touching ways 0..N-1 in sequence.
    // A row is set wherever it was touched after that column's way, so way 0 is LRU.
    function automatic logic lru_reset_bit(input int row, input int col);
        return row > col;
    endfunction

endpackage

// File: rtl/empty_way_select.sv
// Picks the lowest-index clear bit of an occupancy vector, one-hot; all zeros when full.
module empty_way_select #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] occupied,
    output logic [WIDTH-1:0] select
);

    // Adding one ripples through the trailing ones and lands on the lowest zero.
    assign select = ~occupied & (occupied + WIDTH'(1));

endmodule

// File: rtl/lru_matrix.sv
// Matrix LRU for one set: touching way i sets row i and clears column i; the all-zero row is LRU.
module lru_matrix
    import way_allocator_pkg::*;
#(
    parameter int NUM_WAYS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                access_valid,
    input  logic [NUM_WAYS-1:0] access_way,
    input  logic                alloc_valid,
    input  logic [NUM_WAYS-1:0] alloc_way,
    output logic [NUM_WAYS-1:0] lru_way
);

    typedef logic [NUM_WAYS-1:0][NUM_WAYS-1:0] matrix_t;

    matrix_t matrix;
    matrix_t after_access;
    matrix_t after_alloc;

    function automatic matrix_t touch(input matrix_t cur, input logic [NUM_WAYS-1:0] way);
        matrix_t nxt;
        for (int i = 0; i < NUM_WAYS; i++) begin
            for (int j = 0; j < NUM_WAYS; j++) begin
                if (way[j])      nxt[i][j] = 1'b0;
                else if (way[i]) nxt[i][j] = 1'b1;
                else             nxt[i][j] = cur[i][j];
            end
        end
        return nxt;
    endfunction

    // Hit access first, then the fill, so a way filled this cycle ends up MRU.
    always_comb begin
        after_access = matrix;
        after_alloc  = matrix;
        if (access_valid) after_access = touch(matrix, access_way);
        after_alloc = after_access;
        if (alloc_valid) after_alloc = touch(after_access, alloc_way);
    end

    // NOTE: the matrix is a handful of flops, not a RAM, so it is reset to a known order
    // and written with non-blocking assignments like any other state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_WAYS; i++) begin
                for (int j = 0; j < NUM_WAYS; j++) begin
                    matrix[i][j] <= lru_reset_bit(i, j);
                end
            end
        end else begin
            matrix <= after_alloc;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_WAYS; i++) begin
            lru_way[i] = ~|matrix[i];
        end
    end

endmodule

// File: rtl/way_allocator.sv
// Single-set way allocator: grants free ways directly, otherwise evicts the LRU way first.
module way_allocator
    import way_allocator_pkg::*;
#(
    parameter int NUM_WAYS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                alloc_valid,
    output logic                alloc_ready,
    output logic [NUM_WAYS-1:0] alloc_way,
    output logic                alloc_evict,
    output logic                evict_valid,
    output logic [NUM_WAYS-1:0] evict_way,
    input  logic                evict_ready,
    input  logic                access_valid,
    input  logic [NUM_WAYS-1:0] access_way,
    input  logic                free_valid,
    input  logic [NUM_WAYS-1:0] free_way,
    output logic [NUM_WAYS-1:0] ways_in_use
);

    logic [1:0]          state;
    logic [1:0]          state_next;
    logic [NUM_WAYS-1:0] victim;
    logic [NUM_WAYS-1:0] free_sel;
    logic [NUM_WAYS-1:0] lru_way;
    logic [NUM_WAYS-1:0] clear_mask;
    logic [NUM_WAYS-1:0] set_mask;
    logic                set_full;
    logic                handshake;

    empty_way_select #(.WIDTH(NUM_WAYS)) u_empty_way_select (
        .occupied (ways_in_use),
        .select   (free_sel)
    );

    lru_matrix #(.NUM_WAYS(NUM_WAYS)) u_lru_matrix (
        .clock        (clock),
        .reset        (reset),
        .access_valid (access_valid),
        .access_way   (access_way),
        .alloc_valid  (handshake),
        .alloc_way    (alloc_way),
        .lru_way      (lru_way)
    );

    assign set_full = &ways_in_use;

    // Outputs are decoded from registered state only; no input reaches an output.
    always_comb begin
        alloc_ready = 1'b0;
        alloc_way   = '0;
        alloc_evict = 1'b0;
        evict_valid = 1'b0;
        evict_way   = '0;
        case (state)
            ST_IDLE: begin
                alloc_ready = ~set_full;
                alloc_way   = free_sel;
            end
            ST_EVICT: begin
                evict_valid = 1'b1;
                evict_way   = victim;
            end
            ST_GRANT: begin
                alloc_ready = 1'b1;
                alloc_way   = victim;
                alloc_evict = 1'b1;
            end
            default: ;
        endcase
    end

    assign handshake  = alloc_valid & alloc_ready;
    assign clear_mask = free_valid ? free_way : '0;
    assign set_mask   = handshake ? alloc_way : '0;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (set_full && alloc_valid) state_next = ST_EVICT;
            ST_EVICT: if (evict_ready)             state_next = ST_GRANT;
            ST_GRANT: if (handshake)               state_next = ST_IDLE;
            default:                               state_next = ST_IDLE;
        endcase
    end

    // Set is applied after clear so a fill wins over a release of the same way.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= ST_IDLE;
            ways_in_use <= '0;
            victim      <= '0;
        end else begin
            state       <= state_next;
            ways_in_use <= (ways_in_use & ~clear_mask) | set_mask;
            if (state == ST_IDLE && set_full && alloc_valid) victim <= lru_way;
        end
    end

endmodule

// File: tb/tb_way_allocator.sv
// Directed plus randomized bench for way_allocator against a queue-based LRU reference model.
module tb_way_allocator;

    localparam int N = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         alloc_valid;
    logic         alloc_ready;
    logic [N-1:0] alloc_way;
    logic         alloc_evict;
    logic         evict_valid;
    logic [N-1:0] evict_way;
    logic         evict_ready;
    logic         access_valid;
    logic [N-1:0] access_way;
    logic         free_valid;
    logic [N-1:0] free_way;
    logic [N-1:0] ways_in_use;

    int errors = 0;
    int checks = 0;

    way_allocator #(.NUM_WAYS(N)) dut (
        .clock        (clock),
        .reset        (reset),
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .alloc_way    (alloc_way),
        .alloc_evict  (alloc_evict),
        .evict_valid  (evict_valid),
        .evict_way    (evict_way),
        .evict_ready  (evict_ready),
        .access_valid (access_valid),
        .access_way   (access_way),
        .free_valid   (free_valid),
        .free_way     (free_way),
        .ways_in_use  (ways_in_use)
    );

    always #5 clock = ~clock;

    // Reference model: occupancy bits, LRU as an ordered list (front = LRU), and a phase.
    // Phase 0: normal allocation, 1: waiting on writeback, 2: offering the victim.
    int       m_phase;
    int       m_victim;
    bit [N-1:0] m_occ;
    int       lru_q[$];

    function automatic bit [N-1:0] onehot(input int idx);
        bit [N-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic int index_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_phase  = 0;
        m_victim = -1;
        m_occ    = '0;
        lru_q.delete();
        for (int i = 0; i < N; i++) lru_q.push_back(i);
    endtask

    task automatic model_touch(input int way);
        for (int k = 0; k < lru_q.size(); k++) begin
            if (lru_q[k] == way) begin
                lru_q.delete(k);
                break;
            end
        end
        lru_q.push_back(way);
    endtask

    task automatic check(input string tag, input logic [N-1:0] observed, input logic [N-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic drive(input bit av, input bit er, input bit acv, input logic [N-1:0] acw,
                         input bit fv, input logic [N-1:0] fw);
        alloc_valid  = av;
        evict_ready  = er;
        access_valid = acv;
        access_way   = acw;
        free_valid   = fv;
        free_way     = fw;
    endtask

    // Compare every output with the model's view, then advance the model and the clock.
    task automatic step(input string tag);
        bit         e_ready, e_evict, e_evalid, hs, full;
        bit [N-1:0] e_way, e_eway;
        int         first_free, lru_now;
        full       = (m_occ == '1);
        first_free = -1;
        for (int i = N - 1; i >= 0; i--) if (!m_occ[i]) first_free = i;
        e_ready = 1'b0; e_evict = 1'b0; e_evalid = 1'b0; e_way = '0; e_eway = '0;
        if (m_phase == 0) begin
            e_ready = !full;
            if (!full) e_way = onehot(first_free);
        end else if (m_phase == 1) begin
            e_evalid = 1'b1;
            e_eway   = onehot(m_victim);
        end else begin
            e_ready = 1'b1;
            e_way   = onehot(m_victim);
            e_evict = 1'b1;
        end
        check({tag, ".alloc_ready"}, N'(alloc_ready), N'(e_ready));
        check({tag, ".alloc_way"},   alloc_way,       e_way);
        check({tag, ".alloc_evict"}, N'(alloc_evict), N'(e_evict));
        check({tag, ".evict_valid"}, N'(evict_valid), N'(e_evalid));
        check({tag, ".evict_way"},   evict_way,       e_eway);
        check({tag, ".ways_in_use"}, ways_in_use,     m_occ);

        if (!reset) begin
            model_reset();
        end else begin
            hs      = alloc_valid && e_ready;
            lru_now = lru_q[0];
            if (access_valid) model_touch(index_of(access_way));
            if (hs) model_touch(index_of(e_way));
            if (free_valid) m_occ = m_occ & ~free_way;
            if (hs) m_occ = m_occ | e_way;
            case (m_phase)
                0: if (full && alloc_valid) begin m_phase = 1; m_victim = lru_now; end
                1: if (evict_ready) m_phase = 2;
                default: if (hs) m_phase = 0;
            endcase
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, '0, 0, '0);
        @(posedge clock);
        #1;
        model_reset();
        step("reset");
        reset = 1'b1;

        // 1: fill an empty set in index order
        for (int i = 0; i < N; i++) begin
            drive(1, 0, 0, '0, 0, '0);
            check("t1.way_const", alloc_way, onehot(i));
            step("t1.fill");
        end
        check("t1.full", ways_in_use, 8'hFF);
        check("t1.not_ready", N'(alloc_ready), '0);

        // 2: evict reset-order LRU with a stalled writeback
        drive(1, 0, 0, '0, 0, '0);
        step("t2.request");
        check("t2.evict_way", evict_way, 8'h01);
        for (int i = 0; i < 3; i++) step("t2.stall");
        drive(1, 1, 0, '0, 0, '0);
        step("t2.flush");
        drive(1, 0, 0, '0, 0, '0);
        check("t2.grant_way", alloc_way, 8'h01);
        check("t2.grant_evict", N'(alloc_evict), 8'h01);
        step("t2.grant");
        drive(0, 0, 0, '0, 0, '0);
        step("t2.idle");

        // 3: hit accesses reorder LRU before the next eviction
        drive(0, 0, 1, 8'h01, 0, '0); step("t3.acc0");
        drive(0, 0, 1, 8'h02, 0, '0); step("t3.acc1");
        drive(0, 0, 1, 8'h04, 0, '0); step("t3.acc2");
        drive(1, 0, 0, '0, 0, '0);    step("t3.request");
        check("t3.evict_way", evict_way, 8'h08);
        drive(1, 1, 0, '0, 0, '0);    step("t3.flush");
        drive(1, 0, 0, '0, 0, '0);    step("t3.grant");
        drive(0, 0, 0, '0, 0, '0);    step("t3.idle");

        // 4: multi-hot release then two free grants
        drive(0, 0, 0, '0, 1, 8'h24); step("t4.free");
        check("t4.occ", ways_in_use, 8'hDB);
        drive(1, 0, 0, '0, 0, '0);
        check("t4.first", alloc_way, 8'h04);
        step("t4.alloc0");
        check("t4.second", alloc_way, 8'h20);
        step("t4.alloc1");
        drive(0, 0, 0, '0, 0, '0);    step("t4.idle");

        // 5: fill and release of the same way in one cycle; the fill wins
        drive(0, 0, 0, '0, 1, 8'h01); step("t5.free");
        check("t5.occ", ways_in_use, 8'hFE);
        drive(1, 0, 0, '0, 1, 8'h01); step("t5.collide");
        check("t5.result", ways_in_use, 8'hFF);

        // 6: reset while waiting on writeback
        drive(1, 0, 0, '0, 0, '0);    step("t6.request");
        check("t6.in_evict", N'(evict_valid), 8'h01);
        reset = 1'b0;
        drive(0, 0, 0, '0, 0, '0);    step("t6.reset");
        reset = 1'b1;
        check("t6.evict_valid", N'(evict_valid), '0);
        check("t6.occ", ways_in_use, '0);
        check("t6.alloc_way", alloc_way, 8'h01);
        step("t6.after");

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(3) != 0, $urandom_range(2) == 0,
                  $urandom_range(2) == 0, onehot($urandom_range(N - 1)),
                  $urandom_range(7) == 0, N'($urandom));
            reset = ($urandom_range(299) != 0);
            step("rand");
            reset = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
